// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with a host-accessible bank of 8-bit registers
// Optional feature macro: I2C_TARGET_GENCALL_EN (ACK general-call address 0 as a write).
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I2C_SCL_t,
    inout  wire              I2C_SDA_t,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             i2c_wr_stb,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    logic [1:0]       r_scl_sync, r_sda_sync;
    logic [2:0]       r_scl_hist, r_sda_hist;
    logic             r_scl_f, r_sda_f, r_scl_prev, r_sda_prev;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_rw;
    logic [PTR_W-1:0] r_ptr;
    logic             r_ack_phase;
    logic             r_sda_low;
    logic             r_busy;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_bank [NUM_REGS];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;
    logic       w_byte_done, w_ack_end, w_gencall, w_addr_ack, w_bus_we;
    logic [7:0] w_rd_byte;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], I2C_SCL_t};
            r_sda_sync <= {r_sda_sync[0], I2C_SDA_t};
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
            r_scl_f    <= maj3(r_scl_hist);
            r_sda_f    <= maj3(r_sda_hist);
            r_scl_prev <= r_scl_f;
            r_sda_prev <= r_sda_f;
        end
    end

    assign w_scl_rise  = r_scl_f & ~r_scl_prev;
    assign w_scl_fall  = ~r_scl_f & r_scl_prev;
    assign w_start     = r_scl_f & r_scl_prev & r_sda_prev & ~r_sda_f;
    assign w_stop      = r_scl_f & r_scl_prev & ~r_sda_prev & r_sda_f;
    assign w_byte      = {r_shift[6:0], r_sda_f};
    assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7);
    assign w_ack_end   = w_scl_fall && r_ack_phase;
    assign w_rd_byte   = r_bank[r_ptr];

`ifdef I2C_TARGET_GENCALL_EN
    assign w_gencall = (w_byte == 8'h00);
`else
    assign w_gencall = 1'b0;
`endif
    assign w_addr_ack = (w_byte[7:1] == TARGET_ADDR) || w_gencall;
    assign w_bus_we   = (r_state == ST_WDATA) && w_byte_done;

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR:      if (w_byte_done) w_state_nxt = w_addr_ack ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (w_ack_end) w_state_nxt = r_rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (w_byte_done) w_state_nxt = ST_PTR_ACK;
                ST_PTR_ACK:   if (w_ack_end) w_state_nxt = ST_WDATA;
                ST_WDATA:     if (w_byte_done) w_state_nxt = ST_WDATA_ACK;
                ST_WDATA_ACK: if (w_ack_end) w_state_nxt = ST_WDATA;
                ST_RDATA:     if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (w_scl_rise && r_sda_f) w_state_nxt = ST_IGNORE;
                    else if (w_ack_end)        w_state_nxt = ST_RDATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_rw        <= 1'b0;
            r_ptr       <= '0;
            r_ack_phase <= 1'b0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                r_sda_low   <= 1'b0;
            end else if (w_stop) begin
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                r_sda_low   <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (w_byte_done) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == ST_ADDR) begin
                                r_rw   <= w_byte[0];
                                r_busy <= w_addr_ack;
                            end else if (r_state == ST_PTR) begin
                                r_ptr <= w_byte[PTR_W-1:0];
                            end else begin
                                r_wr_stb  <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ptr     <= r_ptr + PTR_W'(1);
                            end
                        end
                    end
                    // First fall drives the ACK low, second fall ends the ACK bit.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall && !r_ack_phase) begin
                            r_sda_low   <= 1'b1;
                            r_ack_phase <= 1'b1;
                        end else if (w_ack_end) begin
                            r_ack_phase <= 1'b0;
                            r_sda_low   <= 1'b0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                r_shift   <= w_rd_byte;
                                r_sda_low <= ~w_rd_byte[7];
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_low <= 1'b0;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_sda_low <= ~r_shift[7];
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_f) begin
                                r_busy <= 1'b0;
                            end else begin
                                r_ack_phase <= 1'b1;
                                r_ptr       <= r_ptr + PTR_W'(1);
                            end
                        end else if (w_ack_end) begin
                            r_ack_phase <= 1'b0;
                            r_shift     <= w_rd_byte;
                            r_sda_low   <= ~w_rd_byte[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Host write is ordered last so it wins a same-index collision with the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= 8'h00;
        end else begin
            if (w_bus_we) r_bank[r_ptr] <= w_byte;
            if (host_we)  r_bank[host_addr] <= host_wdata;
        end
    end

    assign host_rdata  = r_bank[host_addr];
    assign i2c_wr_stb  = r_wr_stb;
    assign i2c_wr_addr = r_wr_addr;
    assign i2c_wr_data = r_wr_data;
    assign busy        = r_busy;
    assign I2C_SDA_t   = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed self-checking bench for i2c_target_regs
`timescale 1ns/1ps
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_scl = 1'b1;
    logic       tb_sda_low = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'h00;
    logic [7:0] host_rdata;
    logic       i2c_wr_stb;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy;
    wire        sda;

    pullup (sda);
    assign sda = tb_sda_low ? 1'b0 : 1'bz;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cnt = 0;
    int drove_cnt = 0;
    logic [3:0] stb_addr [$];
    logic [7:0] stb_data [$];

    i2c_target_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .I2C_SCL_t   (tb_scl),
        .I2C_SDA_t   (sda),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .i2c_wr_stb  (i2c_wr_stb),
        .i2c_wr_addr (i2c_wr_addr),
        .i2c_wr_data (i2c_wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i2c_wr_stb === 1'b1) begin
            stb_addr.push_back(i2c_wr_addr);
            stb_data.push_back(i2c_wr_data);
            stb_cnt++;
        end
        if (sda === 1'b0 && !tb_sda_low) drove_cnt++;
    end

    task automatic quarter();
        repeat (10) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b0; quarter();
        tb_scl = 1'b1;     quarter();
        tb_sda_low = 1'b1; quarter();
        tb_scl = 1'b0;     quarter();
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; quarter();
        tb_scl = 1'b1;     quarter();
        tb_sda_low = 1'b0; quarter();
    endtask

    task automatic send_bit(input logic b);
        tb_sda_low = ~b; quarter();
        tb_scl = 1'b1;   quarter(); quarter();
        tb_scl = 1'b0;   quarter();
    endtask

    task automatic recv_bit(output logic b);
        tb_sda_low = 1'b0; quarter();
        tb_scl = 1'b1;     quarter();
        b = sda;           quarter();
        tb_scl = 1'b0;     quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int dc;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (i2c_wr_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", i2c_wr_stb); end
        n_cmp++; if (i2c_wr_addr !== 4'h0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", i2c_wr_addr); end
        n_cmp++; if (i2c_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", i2c_wr_data); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want 1", sda); end
        host_read(4'd0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_bank0: got %h want 00", d); end
        host_read(4'd15, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_bank15: got %h want 00", d); end
        dc = drove_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        n_cmp++; if (drove_cnt !== dc) begin n_bad++; $display("FAIL idle_scl_drive: got %0d want %0d", drove_cnt, dc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_scl_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] d;
        int s0;
        s0 = stb_cnt;
        bus_start();
        write_byte(8'h84, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_addr_ack: got %b want 1", ack); end
        write_byte(8'h03, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_ptr_ack: got %b want 1", ack); end
        write_byte(8'hA5, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_d0_ack: got %b want 1", ack); end
        write_byte(8'h5A, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_d1_ack: got %b want 1", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_mid: got %b want 1", busy); end
        bus_stop();
        quarter();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        host_read(4'd3, d);
        n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL write_bank3: got %h want a5", d); end
        host_read(4'd4, d);
        n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL write_bank4: got %h want 5a", d); end
        n_cmp++;
        if (stb_cnt !== s0 + 2) begin
            n_bad++; $display("FAIL write_stb_count: got %0d want %0d", stb_cnt - s0, 2);
        end else begin
            if ({stb_addr[s0], stb_data[s0]} !== {4'd3, 8'hA5}) begin
                n_bad++; $display("FAIL write_stb0: got %h/%h want 3/a5", stb_addr[s0], stb_data[s0]);
            end
            n_cmp++;
            if ({stb_addr[s0+1], stb_data[s0+1]} !== {4'd4, 8'h5A}) begin
                n_bad++; $display("FAIL write_stb1: got %h/%h want 4/5a", stb_addr[s0+1], stb_data[s0+1]);
            end
        end
    endtask

    task automatic test_combined_read();
        logic ack;
        logic [7:0] d;
        int dc;
        host_write(4'd7, 8'h11);
        host_write(4'd8, 8'h22);
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h07, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ptr_ack: got %b want 1", ack); end
        bus_start();
        write_byte(8'h85, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
        read_byte(d, 1'b1);
        n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL rd_byte0: got %h want 11", d); end
        read_byte(d, 1'b0);
        n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL rd_byte1: got %h want 22", d); end
        dc = drove_cnt;
        quarter();
        n_cmp++; if (drove_cnt !== dc || sda !== 1'b1) begin n_bad++; $display("FAIL rd_nack_release: got sda %b drives %0d want 1/0", sda, drove_cnt - dc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_nack_busy: got %b want 0", busy); end
        bus_stop();
    endtask

    task automatic test_wrap();
        logic ack;
        logic [7:0] d;
        int s0;
        s0 = stb_cnt;
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h0F, ack);
        write_byte(8'hAA, ack);
        write_byte(8'hBB, ack);
        bus_stop();
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h13, ack);
        write_byte(8'hCC, ack);
        bus_stop();
        host_read(4'd15, d);
        n_cmp++; if (d !== 8'hAA) begin n_bad++; $display("FAIL wrap_bank15: got %h want aa", d); end
        host_read(4'd0, d);
        n_cmp++; if (d !== 8'hBB) begin n_bad++; $display("FAIL wrap_bank0: got %h want bb", d); end
        host_read(4'd3, d);
        n_cmp++; if (d !== 8'hCC) begin n_bad++; $display("FAIL wrap_ptr_mod: got %h want cc", d); end
        n_cmp++;
        if (stb_cnt !== s0 + 3) begin
            n_bad++; $display("FAIL wrap_stb_count: got %0d want 3", stb_cnt - s0);
        end else if (stb_addr[s0+1] !== 4'd0) begin
            n_bad++; $display("FAIL wrap_stb_addr: got %h want 0", stb_addr[s0+1]);
        end
    endtask

    task automatic test_mismatch();
        logic ack;
        int dc;
        dc = drove_cnt;
        bus_start();
        write_byte(8'h90, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL mis_ack: got %b want 0", ack); end
        n_cmp++; if (drove_cnt !== dc) begin n_bad++; $display("FAIL mis_drive: got %0d want 0", drove_cnt - dc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mis_busy: got %b want 0", busy); end
        bus_start();
        write_byte(8'h84, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL mis_retry_ack: got %b want 1", ack); end
        bus_stop();
    endtask

    task automatic test_stop_mid_wdata();
        logic ack;
        logic [7:0] d;
        int s0;
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h05, ack);
        s0 = stb_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        quarter();
        host_read(4'd5, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL partial_bank5: got %h want 00", d); end
        n_cmp++; if (stb_cnt !== s0) begin n_bad++; $display("FAIL partial_stb: got %0d want 0", stb_cnt - s0); end
    endtask

    task automatic test_collision();
        logic ack;
        logic [7:0] d;
        logic [7:0] v;
        int s0;
        int k;
        v = 8'h33;
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h06, ack);
        s0 = stb_cnt;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        tb_sda_low = ~v[0]; quarter();
        host_addr = 4'd6; host_wdata = 8'h99; host_we = 1'b1;
        tb_scl = 1'b1;
        k = 0;
        while (i2c_wr_stb !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        host_we = 1'b0;
        n_cmp++; if (i2c_wr_stb !== 1'b1) begin n_bad++; $display("FAIL coll_stb_timeout: got %b want 1", i2c_wr_stb); end
        quarter();
        tb_scl = 1'b0; quarter();
        recv_bit(ack);
        bus_stop();
        host_read(4'd6, d);
        n_cmp++; if (d !== 8'h99) begin n_bad++; $display("FAIL coll_bank6: got %h want 99", d); end
        n_cmp++;
        if (stb_cnt !== s0 + 1) begin
            n_bad++; $display("FAIL coll_stb_count: got %0d want 1", stb_cnt - s0);
        end else if ({stb_addr[s0], stb_data[s0]} !== {4'd6, 8'h33}) begin
            n_bad++; $display("FAIL coll_stb: got %h/%h want 6/33", stb_addr[s0], stb_data[s0]);
        end
    endtask

    task automatic test_gencall();
        logic ack;
        logic [7:0] d;
        logic       exp_ack;
        logic [7:0] exp_d;
`ifdef I2C_TARGET_GENCALL_EN
        exp_ack = 1'b1; exp_d = 8'h77;
`else
        exp_ack = 1'b0; exp_d = 8'h00;
`endif
        bus_start();
        write_byte(8'h00, ack);
        n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL gc_ack: got %b want %b", ack, exp_ack); end
        write_byte(8'h02, ack);
        write_byte(8'h77, ack);
        bus_stop();
        host_read(4'd2, d);
        n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL gc_bank2: got %h want %h", d, exp_d); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic b;
        logic [7:0] d;
        host_write(4'd9, 8'hF0);
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h09, ack);
        bus_start();
        write_byte(8'h85, ack);
        for (int i = 0; i < 4; i++) recv_bit(b);
        tb_sda_low = 1'b0; quarter();
        tb_scl = 1'b1; quarter();
        n_cmp++; if (sda !== 1'b0) begin n_bad++; $display("FAIL rst_rd_bit4: got %b want 0", sda); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rst_rd_sda: got %b want 1", sda); end
        n_cmp++; if ({busy, i2c_wr_stb, i2c_wr_addr, i2c_wr_data} !== 14'd0) begin
            n_bad++; $display("FAIL rst_rd_outputs: got %b/%b/%h/%h want 0/0/0/00", busy, i2c_wr_stb, i2c_wr_addr, i2c_wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        host_read(4'd9, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_rd_bank9: got %h want 00", d); end
        tb_scl = 1'b0; quarter();
        bus_stop();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_rd_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_combined_read();
        test_wrap();
        test_mismatch();
        test_stop_mid_wdata();
        test_collision();
        test_gencall();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
